// File: rtl/combinational_to_sequencer_pkg.sv
// Shared types and defaults for the combinational_to walking-one sequencer.
package combinational_to_sequencer_pkg;

  // Datapath width and matching index width (2**INDEX_W >= WIDTH)
  localparam int unsigned WIDTH_DEF   = 6;
  localparam int unsigned INDEX_W_DEF = 3;

  // Settle interval default and the counter width covering 1..15
  localparam int unsigned SETTLE_DEF  = 1;
  localparam int unsigned CNT_W       = 4;

  // Sequencer states; encodings are fixed so logs and probes stay readable
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Countdown reload: the zero flag is checked on the last settle cycle
  function automatic logic [CNT_W-1:0] settle_reload(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/combinational_to_sequencer_settle_timer.sv
// Settle countdown for the sequencer.
//   clk, reset : clock and synchronous active-high reset
//   load       : load 'value' into the counter (wins over dec)
//   value      : reload value (settle cycles minus one)
//   dec        : count down by one, saturating at zero
//   zero_c     : combinational flag, counter is zero
module combinational_to_sequencer_settle_timer
  import combinational_to_sequencer_pkg::*;
#(
  parameter int unsigned TIMER_W = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               dec,
  output logic               zero_c
);

  logic [TIMER_W-1:0] cnt_q;

  // Counter register: load has priority, decrement stops at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/combinational_to_sequencer.sv
// Walking-one sequencer for the combinational_to datapath: drives 1,2,4..MSB on
// dut_x, waits SETTLE_CYCLES, captures dut_x/dut_y and streams each pair out on
// a valid/ready handshake, then pulses done.
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : sweep control (start sampled in IDLE only, abort wins)
//   busy, done        : sweep in progress / one-cycle completion pulse
//   dut_x, dut_y      : registered datapath drive and its combinational response
//   res_valid/ready   : result handshake
//   res_x, res_y      : captured vector and response
//   res_index         : bit position of the set bit in res_x
module combinational_to_sequencer
  import combinational_to_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH         = WIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF,
  parameter int unsigned INDEX_W       = INDEX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dut_x,
  input  logic [WIDTH-1:0]   dut_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_x,
  output logic [WIDTH-1:0]   res_y,
  output logic [INDEX_W-1:0] res_index
);

  state_e               state;
  logic [INDEX_W-1:0]   index_q;
  logic                 last_vec_c;
  logic                 accept_c;
  logic                 tmr_load_c;
  logic                 tmr_dec_c;
  logic                 tmr_zero_c;

  // The MSB vector is the final one; the walking one never shifts out
  assign last_vec_c = dut_x[WIDTH-1];
  assign accept_c   = (state == ST_HOLD) && res_ready;

  // Timer reloads exactly when the FSM enters SETTLE
  assign tmr_load_c = !abort &&
                      (((state == ST_IDLE) && start) ||
                       (accept_c && !last_vec_c));
  assign tmr_dec_c  = !abort && (state == ST_SETTLE);

  combinational_to_sequencer_settle_timer #(
    .TIMER_W (CNT_W)
  ) u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load_c),
    .value  (settle_reload(SETTLE_CYCLES)),
    .dec    (tmr_dec_c),
    .zero_c (tmr_zero_c)
  );

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dut_x     <= '0;
      index_q   <= '0;
      res_x     <= '0;
      res_y     <= '0;
      res_index <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Captured result registers intentionally keep their last values
        state     <= ST_IDLE;
        dut_x     <= '0;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              dut_x   <= WIDTH'(1);
              index_q <= '0;
              busy    <= 1'b1;
              state   <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (tmr_zero_c) begin
              res_x     <= dut_x;
              res_y     <= dut_y;
              res_index <= index_q;
              res_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (accept_c) begin
              res_valid <= 1'b0;
              if (last_vec_c) begin
                state <= ST_DONE;
              end else begin
                dut_x   <= dut_x << 1;
                index_q <= index_q + INDEX_W'(1);
                state   <= ST_SETTLE;
              end
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            dut_x <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_combinational_to_sequencer.sv
// Directed bench for combinational_to_sequencer. A stand-in datapath
// (rotate-right by one, xor 6'h2A) answers dut_x on dut_y; instance a uses a
// one-cycle settle, instance b a three-cycle settle.
module tb_combinational_to_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       abort;
  logic       res_ready;
  logic       start_a, start_b;

  logic       busy_a, done_a, res_valid_a;
  logic [5:0] dut_x_a, dut_y_a, res_x_a, res_y_a;
  logic [2:0] res_index_a;
  logic       busy_b, done_b, res_valid_b;
  logic [5:0] dut_x_b, dut_y_b, res_x_b, res_y_b;
  logic [2:0] res_index_b;

  int checks = 0;
  int errors = 0;

  // Hand-computed responses for x = 1,2,4,8,16,32
  logic [5:0] exp_y [6] = '{6'h0A, 6'h2B, 6'h28, 6'h2E, 6'h22, 6'h3A};

  always #5 clk = ~clk;

  assign dut_y_a = {dut_x_a[0], dut_x_a[5:1]} ^ 6'h2A;
  assign dut_y_b = {dut_x_b[0], dut_x_b[5:1]} ^ 6'h2A;

  combinational_to_sequencer #(.WIDTH(6), .SETTLE_CYCLES(1), .INDEX_W(3)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort),
    .busy(busy_a), .done(done_a), .dut_x(dut_x_a), .dut_y(dut_y_a),
    .res_valid(res_valid_a), .res_ready(res_ready),
    .res_x(res_x_a), .res_y(res_y_a), .res_index(res_index_a)
  );

  combinational_to_sequencer #(.WIDTH(6), .SETTLE_CYCLES(3), .INDEX_W(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort),
    .busy(busy_b), .done(done_b), .dut_x(dut_x_b), .dut_y(dut_y_b),
    .res_valid(res_valid_b), .res_ready(res_ready),
    .res_x(res_x_b), .res_y(res_y_b), .res_index(res_index_b)
  );

  // Instance selector used by the sweep task
  bit         sel_b = 1'b0;
  logic       cur_busy, cur_done, cur_valid;
  logic [5:0] cur_dut_x, cur_res_x, cur_res_y;
  logic [2:0] cur_res_index;
  assign cur_busy      = sel_b ? busy_b      : busy_a;
  assign cur_done      = sel_b ? done_b      : done_a;
  assign cur_valid     = sel_b ? res_valid_b : res_valid_a;
  assign cur_dut_x     = sel_b ? dut_x_b     : dut_x_a;
  assign cur_res_x     = sel_b ? res_x_b     : res_x_a;
  assign cur_res_y     = sel_b ? res_y_b     : res_y_a;
  assign cur_res_index = sel_b ? res_index_b : res_index_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input bit v);
    if (sel_b) start_b = v;
    else       start_a = v;
  endtask

  // Runs one sweep from a start pulse; n counts clock edges after the start edge
  task automatic sweep(input bit use_b, input int settle, input int stall_vec,
                       input int stall_len, input int rp0, input int rp1,
                       input int max_cyc, output int nres, output int ndone,
                       output int done_at);
    int  k         = 0;
    int  stall_cnt = 0;
    int  last_hs   = 0;
    bit  prev_v    = 1'b0;
    sel_b   = use_b;
    ndone   = 0;
    done_at = -1;
    res_ready = 1'b1;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      drive_start((n == rp0) || (n == rp1));
      res_ready = 1'b1;
      if (cur_done) begin
        ndone++;
        done_at = n;
        check("done_busy_low", 32'(cur_busy), 32'd0);
        check("done_dutx_zero", 32'(cur_dut_x), 32'd0);
      end
      if (cur_valid) begin
        if (!prev_v) check("valid_latency", 32'(n - last_hs), 32'(settle));
        if ((k == stall_vec) && (stall_cnt < stall_len)) begin
          res_ready = 1'b0;
          stall_cnt++;
          check("stall_res_x", 32'(cur_res_x), 32'(1) << k);
          check("stall_res_y", 32'(cur_res_y), 32'(exp_y[k]));
          check("stall_dut_x", 32'(cur_dut_x), 32'(1) << k);
        end else begin
          if (k < 6) begin
            check("res_x", 32'(cur_res_x), 32'(1) << k);
            check("res_y", 32'(cur_res_y), 32'(exp_y[k]));
            check("res_index", 32'(cur_res_index), 32'(k));
          end
          k++;
          last_hs = n + 1;
        end
      end
      prev_v = cur_valid;
    end
    drive_start(1'b0);
    res_ready = 1'b1;
    nres = k;
  endtask

  initial begin
    int  nres, ndone, done_at, cnt;
    bit  found;

    reset = 1'b1; abort = 1'b0; res_ready = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(res_valid_a), 32'd0);
    check("rst_dut_x", 32'(dut_x_a), 32'd0);
    check("rst_res_x", 32'(res_x_a), 32'd0);
    check("rst_res_y", 32'(res_y_a), 32'd0);
    check("rst_res_index", 32'(res_index_a), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Plain sweep, ready always high
    sweep(1'b0, 1, -1, 0, 0, 0, 30, nres, ndone, done_at);
    check("t1_nres", 32'(nres), 32'd6);
    check("t1_ndone", 32'(ndone), 32'd1);
    check("t1_done_at", 32'(done_at), 32'd13);

    // Consumer stalls 5 cycles on vector 2
    sweep(1'b0, 1, 2, 5, 0, 0, 30, nres, ndone, done_at);
    check("t2_nres", 32'(nres), 32'd6);
    check("t2_ndone", 32'(ndone), 32'd1);
    check("t2_done_at", 32'(done_at), 32'd18);

    // Abort coinciding with the handshake of vector 3
    sel_b = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (res_valid_a && (res_index_a == 3'd3)) found = 1'b1;
    end
    check("t3_reach_vec3", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t3_busy", 32'(busy_a), 32'd0);
    check("t3_valid", 32'(res_valid_a), 32'd0);
    check("t3_dut_x", 32'(dut_x_a), 32'd0);
    check("t3_res_x_kept", 32'(res_x_a), 32'd8);
    check("t3_res_index_kept", 32'(res_index_a), 32'd3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a || busy_a) cnt++;
    end
    check("t3_no_done", 32'(cnt), 32'd0);
    sweep(1'b0, 1, -1, 0, 0, 0, 30, nres, ndone, done_at);
    check("t3_restart_nres", 32'(nres), 32'd6);
    check("t3_restart_done_at", 32'(done_at), 32'd13);

    // Start re-pulsed mid-sweep and in the DONE cycle
    sweep(1'b0, 1, -1, 0, 5, 12, 30, nres, ndone, done_at);
    check("t4_nres", 32'(nres), 32'd6);
    check("t4_ndone", 32'(ndone), 32'd1);
    check("t4_done_at", 32'(done_at), 32'd13);

    // Reset during SETTLE of vector 4, then abort+start together in IDLE
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if ((dut_x_a == 6'd16) && !res_valid_a) found = 1'b1;
    end
    check("t5_reach_vec4", 32'(found), 32'd1);
    check("t5_busy_before", 32'(busy_a), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy", 32'(busy_a), 32'd0);
    check("t5_dut_x", 32'(dut_x_a), 32'd0);
    check("t5_valid", 32'(res_valid_a), 32'd0);
    check("t5_res_x", 32'(res_x_a), 32'd0);
    check("t5_res_y", 32'(res_y_a), 32'd0);
    check("t5_res_index", 32'(res_index_a), 32'd0);
    abort = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_a = 1'b0;
    check("t5_abort_start_busy", 32'(busy_a), 32'd0);
    check("t5_abort_start_dut_x", 32'(dut_x_a), 32'd0);
    @(negedge clk);
    check("t5_still_idle", 32'(busy_a), 32'd0);

    // Three-cycle settle on instance b
    sweep(1'b1, 3, -1, 0, 0, 0, 40, nres, ndone, done_at);
    check("t6_nres", 32'(nres), 32'd6);
    check("t6_ndone", 32'(ndone), 32'd1);
    check("t6_done_at", 32'(done_at), 32'd25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
